// File: rtl/fc_reset_pkg.sv
// ----------------------------------------------------------------------------
// fc_reset_pkg
// Shared definitions for the fast-control reset sequencer:
//   - seq_state_t : sequencer FSM states (HOLD, WAIT_LOCK, RELEASE, RUN)
//   - DEF_*       : default values for the sequencer parameters
//   - cnt_width() : width of the shared hold/gap counter
// ----------------------------------------------------------------------------
package fc_reset_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int DEF_N_DOM    = 4;
    localparam int DEF_HOLD_CYC = 16;
    localparam int DEF_GAP_CYC  = 8;

    // One counter serves both the hold phase and the inter-domain gap, so it
    // is sized for the longer of the two plus a spare bit so that it never
    // wraps inside a phase.
    function automatic int cnt_width(input int hold_cyc, input int gap_cyc);
        return $clog2((hold_cyc > gap_cyc) ? hold_cyc : gap_cyc) + 1;
    endfunction

endpackage

// File: rtl/fc_reset_sync2.sv
// ----------------------------------------------------------------------------
// fc_reset_sync2
// Two-flop reset synchronizer: asserts asynchronously with resetb, releases
// on the second rising clk edge after resetb rises.
// Ports:
//   clk     in  : fast-control clock
//   resetb  in  : board reset, asynchronous, active-low
//   rst_s_n out : synchronized reset, active-low
// ----------------------------------------------------------------------------
module fc_reset_sync2 (
    input  logic clk,
    input  logic resetb,
    output logic rst_s_n
);

    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= 1'b1;
            sync_q2 <= sync_q1;
        end
    end

    assign rst_s_n = sync_q2;

endmodule

// File: rtl/fc_reset_sequencer.sv
// ----------------------------------------------------------------------------
// fc_reset_sequencer
// Ordered reset sequencer for the fast-control clock domain. Holds all
// downstream domains in reset for HOLD_CYC cycles after the synchronized
// reset releases, waits for PLL lock, then releases the domain resets one by
// one, GAP_CYC cycles apart, in ascending order. A soft reset command, or
// loss of lock while releasing/running, restarts the sequence from HOLD.
//
// Build option: define FC_RSTSEQ_EVTCNT_EN to enable the saturating count of
// completed sequences on evt_cnt; otherwise evt_cnt is tied to 0.
//
// Ports:
//   clk          in  : 40 MHz fast-control clock
//   resetb       in  : board reset, asynchronous, active-low
//   pll_lock     in  : PLL lock level, synchronous to clk
//   cmd_soft_rst in  : one-cycle soft reset pulse from the fast-command decoder
//   rst_dom_b    out : per-domain resets, active-low, registered
//   seq_busy     out : high while any domain is held or pending release
//   seq_done     out : one-cycle pulse after the last domain releases
//   evt_cnt      out : number of completed sequences (0 when disabled)
//
// Handshake: there is none; cmd_soft_rst is a single-cycle strobe that is
// acted on in the cycle it is sampled, with no acknowledge.
// ----------------------------------------------------------------------------
module fc_reset_sequencer
    import fc_reset_pkg::*;
#(
    parameter int N_DOM    = DEF_N_DOM,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int GAP_CYC  = DEF_GAP_CYC
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             pll_lock,
    input  logic             cmd_soft_rst,
    output logic [N_DOM-1:0] rst_dom_b,
    output logic             seq_busy,
    output logic             seq_done,
    output logic [15:0]      evt_cnt
);

    localparam int CW = cnt_width(HOLD_CYC, GAP_CYC);
    localparam int IW = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    logic rst_s_n;

    fc_reset_sync2 u_sync (
        .clk     (clk),
        .resetb  (resetb),
        .rst_s_n (rst_s_n)
    );

    seq_state_t       state,     state_n;
    logic [CW-1:0]    cnt,       cnt_n;
    logic [IW-1:0]    idx,       idx_n;
    logic [N_DOM-1:0] dom_q,     dom_n;
    logic             run_entry, run_entry_n;
    logic             busy_q,    busy_n;
    logic             done_q,    done_n;
    logic             restart;

    // Lock loss only matters once the release has started; during HOLD and
    // WAIT_LOCK everything is still held, so there is nothing to undo.
    assign restart = cmd_soft_rst |
                     (~pll_lock & ((state == RELEASE) | (state == RUN)));

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        dom_n       = dom_q;
        run_entry_n = 1'b0;

        if (restart) begin
            state_n = HOLD;
            cnt_n   = '0;
            idx_n   = '0;
            dom_n   = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == CW'(HOLD_CYC - 1)) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (pll_lock) begin
                        state_n = RELEASE;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end
                end
                RELEASE: begin
                    // The current domain is released on the first cycle of
                    // its gap window; the rest of the window is the spacing
                    // to the next domain.
                    if (cnt == '0) begin
                        dom_n[idx] = 1'b1;
                    end
                    if ((cnt == '0) && (idx == IW'(N_DOM - 1))) begin
                        state_n     = RUN;
                        run_entry_n = 1'b1;
                        cnt_n       = '0;
                    end else if (cnt == CW'(GAP_CYC - 1)) begin
                        cnt_n = '0;
                        idx_n = idx + IW'(1);
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                RUN: begin
                    state_n = RUN;
                end
                default: begin
                    state_n = HOLD;
                    cnt_n   = '0;
                    idx_n   = '0;
                    dom_n   = '0;
                end
            endcase
        end

        // Status lags the state by one edge so it follows the last release.
        busy_n = ~((state == RUN) & ~restart);
        done_n = run_entry & (state == RUN) & ~restart;
    end

    always_ff @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            state     <= HOLD;
            cnt       <= '0;
            idx       <= '0;
            dom_q     <= '0;
            run_entry <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            dom_q     <= dom_n;
            run_entry <= run_entry_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
        end
    end

    assign rst_dom_b = dom_q;
    assign seq_busy  = busy_q;
    assign seq_done  = done_q;

`ifdef FC_RSTSEQ_EVTCNT_EN
    // Counts alongside seq_done; only the synchronized board reset clears it.
    logic [15:0] evt_q;

    always_ff @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            evt_q <= '0;
        end else if (done_n && (evt_q != 16'hFFFF)) begin
            evt_q <= evt_q + 16'd1;
        end
    end

    assign evt_cnt = evt_q;
`else
    assign evt_cnt = '0;
`endif

endmodule

// File: tb/tb_fc_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fc_reset_sequencer
// Self-checking bench for fc_reset_sequencer. The reference model tracks the
// sequence by edge timestamps: the edge at which hold starts and the edge at
// which lock is accepted; every output is derived from those two numbers.
// ----------------------------------------------------------------------------
module tb_fc_reset_sequencer;

    localparam int N_DOM    = 4;
    localparam int HOLD_CYC = 16;
    localparam int GAP_CYC  = 8;

`ifdef FC_RSTSEQ_EVTCNT_EN
    localparam bit EVT_EN = 1'b1;
`else
    localparam bit EVT_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             resetb;
    logic             pll_lock;
    logic             cmd_soft_rst;
    logic [N_DOM-1:0] rst_dom_b;
    logic             seq_busy;
    logic             seq_done;
    logic [15:0]      evt_cnt;

    always #5 clk = ~clk;

    fc_reset_sequencer #(
        .N_DOM    (N_DOM),
        .HOLD_CYC (HOLD_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk          (clk),
        .resetb       (resetb),
        .pll_lock     (pll_lock),
        .cmd_soft_rst (cmd_soft_rst),
        .rst_dom_b    (rst_dom_b),
        .seq_busy     (seq_busy),
        .seq_done     (seq_done),
        .evt_cnt      (evt_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    // Model: m_s = edge of first hold cycle, m_e = edge lock accepted (-1 none)
    int  m_s       = 0;
    int  m_e       = -1;
    int  m_act     = 1 << 30;
    bit  m_rst_low = 1'b1;
    int  m_done_cnt = 0;

    logic [N_DOM-1:0] exp_dom;
    logic             exp_busy;
    logic             exp_done;
    logic [15:0]      exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic model_edge(input logic rb, input logic lk, input logic sr);
        int t;
        int last_done;
        edge_no++;
        t = edge_no;
        if (!rb) begin
            m_rst_low  = 1'b1;
            m_e        = -1;
            m_done_cnt = 0;
        end else if (m_rst_low) begin
            m_rst_low = 1'b0;
            m_act     = t + 2;
            m_s       = t + 2;
            m_e       = -1;
        end else if (t >= m_act) begin
            if (sr || (m_e >= 0 && t > m_e && !lk)) begin
                m_s = t + 1;
                m_e = -1;
            end else if (m_e < 0 && t >= m_s + HOLD_CYC && lk) begin
                m_e = t;
            end
        end
        exp_dom  = '0;
        exp_busy = 1'b1;
        exp_done = 1'b0;
        if (!m_rst_low && m_e >= 0) begin
            for (int k = 0; k < N_DOM; k++)
                exp_dom[k] = (t >= m_e + 1 + k * GAP_CYC);
            last_done = m_e + 2 + (N_DOM - 1) * GAP_CYC;
            exp_done  = (t == last_done);
            exp_busy  = (t < last_done);
        end
        if (exp_done) begin
            m_done_cnt++;
            exp_q.push_back(EVT_EN ? 16'(m_done_cnt) : 16'd0);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        model_edge(resetb, pll_lock, cmd_soft_rst);
        #1;
        check("rst_dom_b", 32'(rst_dom_b), 32'(exp_dom));
        check("seq_busy", 32'(seq_busy), 32'(exp_busy));
        check("seq_done", 32'(seq_done), 32'(exp_done));
        check("evt_cnt", 32'(evt_cnt), EVT_EN ? 32'(m_done_cnt) : 32'd0);
        if (seq_done === 1'b1) begin
            check("done_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("done_evt", 32'(evt_cnt), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic run_until_edge(input int target);
        while (edge_no < target) step();
    endtask

    task automatic wait_dom(input logic [N_DOM-1:0] v, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_dom == v && m_e >= 0) return;
            step();
        end
        check("wait_dom_timeout", 32'(exp_dom), 32'(v));
    endtask

    task automatic pulse_soft();
        cmd_soft_rst = 1'b1;
        step();
        cmd_soft_rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int e0;
    int t0;
    int lock_low;
    int rst_low;
    bit found;

    initial begin
        resetb       = 1'b0;
        pll_lock     = 1'b1;
        cmd_soft_rst = 1'b0;
        repeat (3) step();

        // Power-up with lock high
        resetb = 1'b1;
        e0 = edge_no + 1;
        run_until_edge(e0 + 18);
        check("pwr_e18_dom", 32'(rst_dom_b), 32'h0);
        step();
        check("pwr_e19_dom", 32'(rst_dom_b), 32'h1);
        run_until_edge(e0 + 27);
        check("pwr_e27_dom", 32'(rst_dom_b), 32'h3);
        run_until_edge(e0 + 35);
        check("pwr_e35_dom", 32'(rst_dom_b), 32'h7);
        run_until_edge(e0 + 43);
        check("pwr_e43_dom", 32'(rst_dom_b), 32'hF);
        check("pwr_e43_busy", 32'(seq_busy), 32'd1);
        step();
        check("pwr_e44_done", 32'(seq_done), 32'd1);
        check("pwr_e44_busy", 32'(seq_busy), 32'd0);
        check("pwr_e44_evt", 32'(evt_cnt), EVT_EN ? 32'd1 : 32'd0);
        step();
        check("pwr_e45_done", 32'(seq_done), 32'd0);
        repeat (4) step();

        // Soft reset in RUN
        pulse_soft();
        t0 = edge_no;
        step();
        check("soft_t1_dom", 32'(rst_dom_b), 32'h0);
        check("soft_t1_busy", 32'(seq_busy), 32'd1);
        run_until_edge(t0 + 17);
        check("soft_t17_dom", 32'(rst_dom_b), 32'h0);
        step();
        check("soft_t18_dom", 32'(rst_dom_b), 32'h1);
        run_until_edge(t0 + 43);
        check("soft_t43_done", 32'(seq_done), 32'd1);
        check("soft_t43_evt", 32'(evt_cnt), EVT_EN ? 32'd2 : 32'd0);
        repeat (3) step();

        // Lock loss while 0011 is released, then resequence
        pulse_soft();
        wait_dom(4'b0011, 200);
        pll_lock = 1'b0;
        step();
        check("lockloss_dom", 32'(rst_dom_b), 32'h0);
        repeat ($urandom_range(1, 20)) step();
        pll_lock = 1'b1;
        repeat (60) step();

        // Board reset mid-RELEASE: asynchronous clear, full restart
        pulse_soft();
        wait_dom(4'b0011, 200);
        resetb = 1'b0;
        #1;
        check("async_dom", 32'(rst_dom_b), 32'h0);
        check("async_busy", 32'(seq_busy), 32'd1);
        check("async_done", 32'(seq_done), 32'd0);
        check("async_evt", 32'(evt_cnt), 32'd0);
        repeat (2) step();
        resetb = 1'b1;
        e0 = edge_no + 1;
        run_until_edge(e0 + 19);
        check("rst_e19_dom", 32'(rst_dom_b), 32'h1);
        repeat (30) step();

        // Late lock: held low until edge 30 after reset
        resetb   = 1'b0;
        pll_lock = 1'b0;
        repeat (3) step();
        resetb = 1'b1;
        e0 = edge_no + 1;
        run_until_edge(e0 + 29);
        pll_lock = 1'b1;
        step();
        check("late_e30_dom", 32'(rst_dom_b), 32'h0);
        step();
        check("late_e31_dom", 32'(rst_dom_b), 32'h1);

        // Soft reset coincident with the last release
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_e >= 0 && edge_no + 1 == m_e + 1 + (N_DOM - 1) * GAP_CYC)
                found = 1'b1;
            else
                step();
        end
        check("wait_last_release", 32'(found), 32'd1);
        pulse_soft();
        check("coinc_dom", 32'(rst_dom_b), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("coinc_no_done", 32'(seq_done), 32'd0);
        end
        repeat (50) step();

        // Randomized soft resets, lock glitches and board resets
        lock_low = 0;
        rst_low  = 0;
        for (int i = 0; i < 800; i++) begin
            cmd_soft_rst = ($urandom_range(0, 63) == 0);
            if (lock_low > 0) begin
                lock_low--;
                pll_lock = 1'b0;
            end else begin
                pll_lock = 1'b1;
                if ($urandom_range(0, 49) == 0) lock_low = $urandom_range(1, 12);
            end
            if (rst_low > 0) begin
                rst_low--;
                resetb = 1'b0;
            end else begin
                resetb = 1'b1;
                if ($urandom_range(0, 399) == 0) rst_low = 2;
            end
            step();
        end
        cmd_soft_rst = 1'b0;
        pll_lock     = 1'b1;
        resetb       = 1'b1;
        repeat (60) step();

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
